// File: rtl/adder_pkg.sv
// Shared constants and stage-count helper for the segmented pipelined adder.
package adder_pkg;

    localparam int WA_DEF  = 41;
    localparam int WB_DEF  = 7;
    localparam int SEG_DEF = 14;

    // One pipeline stage per carry segment; the last segment may be narrower.
    function automatic int nstg(input int wa, input int seg);
        return (wa + seg - 1) / seg;
    endfunction

endpackage

// File: rtl/pipelined_seg_adder_if.sv
// Operand/result handshake bundle for pipelined_seg_adder.
interface pipelined_seg_adder_if #(
    parameter int WA = 41,
    parameter int WB = 7
) ();

    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          b_sext;
    logic          out_valid;
    logic          out_ready;
    logic [WA:0]   sum;

    modport master (
        output in_valid, a, b, b_sext, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  in_valid, a, b, b_sext, out_ready,
        output in_ready, out_valid, sum
    );

endinterface

// File: rtl/adder_seg_stage.sv
// One carry segment of the pipelined adder: adds bits K*SEG.. of the operands
// with the incoming carry and registers partial sum, operands, carry and valid.
module adder_seg_stage
    import adder_pkg::*;
#(
    parameter int WA  = WA_DEF,
    parameter int SEG = SEG_DEF,
    parameter int K   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    input  logic          prev_vld,
    input  logic [WA-1:0] prev_a,
    input  logic [WA-1:0] prev_bx,
    input  logic [WA:0]   prev_sum,
    input  logic          prev_c,
    output logic          vld,
    output logic [WA-1:0] a,
    output logic [WA-1:0] bx,
    output logic [WA:0]   sum,
    output logic          c
);

    localparam int LO   = K * SEG;
    localparam int W    = ((WA - LO) < SEG) ? (WA - LO) : SEG;
    localparam bit LAST = ((LO + W) == WA);

    logic [W:0]  seg_res;
    logic [WA:0] sum_nxt;

    assign seg_res = {1'b0, prev_a[LO +: W]} + {1'b0, prev_bx[LO +: W]} + {{W{1'b0}}, prev_c};

    always_comb begin
        sum_nxt           = prev_sum;
        sum_nxt[LO +: W]  = seg_res[W-1:0];
        if (LAST) sum_nxt[WA] = seg_res[W];
    end

    // Data only loads with a valid token so the output keeps the last real result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= 1'b0;
            a   <= '0;
            bx  <= '0;
            sum <= '0;
            c   <= 1'b0;
        end else if (adv) begin
            vld <= prev_vld;
            if (prev_vld) begin
                a   <= prev_a;
                bx  <= prev_bx;
                sum <= sum_nxt;
                c   <= seg_res[W];
            end
        end
    end

endmodule

// File: rtl/pipelined_seg_adder.sv
// Pipelined A + ext(B) adder, one carry segment per stage, full throughput.
// Optional ADDER_XFER_CNT_EN adds a saturating 16-bit output-transfer counter.
module pipelined_seg_adder
    import adder_pkg::*;
#(
    parameter int WA  = WA_DEF,
    parameter int WB  = WB_DEF,
    parameter int SEG = SEG_DEF
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_seg_adder_if.slave bus
`ifdef ADDER_XFER_CNT_EN
    ,
    output logic [15:0] xfer_cnt
`endif
);

    localparam int NSTG = nstg(WA, SEG);

    logic                  adv;
    logic [WA-1:0]         bx;
    logic [NSTG:0]         vld_pipe;
    logic [NSTG:0]         c_pipe;
    logic [NSTG:0][WA-1:0] a_pipe;
    logic [NSTG:0][WA-1:0] bx_pipe;
    logic [NSTG:0][WA:0]   sum_pipe;
    logic                  unused_tail;

    always_comb begin
        bx         = {WA{bus.b_sext & bus.b[WB-1]}};
        bx[WB-1:0] = bus.b;
    end

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign adv          = !vld_pipe[NSTG] || bus.out_ready;
    assign bus.in_ready = adv;

    assign vld_pipe[0] = bus.in_valid;
    assign a_pipe[0]   = bus.a;
    assign bx_pipe[0]  = bx;
    assign sum_pipe[0] = '0;
    assign c_pipe[0]   = 1'b0;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        adder_seg_stage #(
            .WA  (WA),
            .SEG (SEG),
            .K   (k)
        ) u_stg (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .prev_vld (vld_pipe[k]),
            .prev_a   (a_pipe[k]),
            .prev_bx  (bx_pipe[k]),
            .prev_sum (sum_pipe[k]),
            .prev_c   (c_pipe[k]),
            .vld      (vld_pipe[k+1]),
            .a        (a_pipe[k+1]),
            .bx       (bx_pipe[k+1]),
            .sum      (sum_pipe[k+1]),
            .c        (c_pipe[k+1])
        );
    end

    assign bus.out_valid = vld_pipe[NSTG];
    assign bus.sum       = sum_pipe[NSTG];

    assign unused_tail = ^{a_pipe[NSTG], bx_pipe[NSTG], c_pipe[NSTG]};

`ifdef ADDER_XFER_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            xfer_cnt <= '0;
        else if (bus.out_valid && bus.out_ready && (xfer_cnt != 16'hFFFF))
            xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pipelined_seg_adder.sv
// Directed + random bench for pipelined_seg_adder against an arithmetic reference queue.
module tb_pipelined_seg_adder;
    import adder_pkg::*;

    localparam int WA   = 41;
    localparam int WB   = 7;
    localparam int SEG  = 14;
    localparam int NSTG = nstg(WA, SEG);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_seg_adder_if #(.WA(WA), .WB(WB)) bus ();
`ifdef ADDER_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    pipelined_seg_adder #(.WA(WA), .WB(WB), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ADDER_XFER_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    int          n_xfer = 0;
    logic [WA:0] exp_q[$];
    logic [63:0] ra;
    logic [31:0] rb;

    // Reference: treat B as a signed/unsigned integer, add, keep WA+1 bits.
    function automatic logic [WA:0] ref_sum(input logic [WA-1:0] av, input logic [WB-1:0] bv, input logic s);
        longint unsigned bval = 64'(bv);
        longint unsigned r;
        if (s && bv[WB-1]) bval = bval + (64'd1 << WA) - (64'd1 << WB);
        r = (64'(av) + bval) & ((64'd1 << (WA + 1)) - 64'd1);
        return r[WA:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, score output transfer / input accept before the edge, step.
    task automatic cyc(input logic v, input logic [WA-1:0] av, input logic [WB-1:0] bv,
                       input logic s, input logic ordy);
        logic [WA:0] e;
        bus.in_valid  = v;
        bus.a         = av;
        bus.b         = bv;
        bus.b_sext    = s;
        bus.out_ready = ordy;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) chk("unexpected_out", 64'(exp_q.size()), 64'd1);
            else begin
                e = exp_q.pop_front();
                chk("sum_order", 64'(bus.sum), 64'(e));
            end
        end
        if (v && bus.in_ready) exp_q.push_back(ref_sum(av, bv, s));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic rnd();
        ra = {$urandom(), $urandom()};
        rb = $urandom();
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.b_sext = 1'b0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Full carry ripple through all segments; result visible after the third edge.
        cyc(1'b1, 41'h1FF_FFFF_FFFF, 7'h01, 1'b0, 1'b1);
        chk("lat_e0", 64'(bus.out_valid), 64'd0);
        idle(1);
        chk("lat_e1", 64'(bus.out_valid), 64'd0);
        idle(1);
        chk("lat_e2_valid", 64'(bus.out_valid), 64'd1);
        chk("ripple_sum", 64'(bus.sum), 64'h200_0000_0000);
        idle(2);

        // Sign vs zero extension of B.
        cyc(1'b1, 41'h5, 7'h7F, 1'b1, 1'b1);
        cyc(1'b1, 41'h5, 7'h7F, 1'b0, 1'b1);
        idle(1);
        chk("sext_valid", 64'(bus.out_valid), 64'd1);
        chk("sext_sum", 64'(bus.sum), 64'h200_0000_0004);
        idle(1);
        chk("zext_sum", 64'(bus.sum), 64'h000_0000_0084);
        idle(NSTG + 1);
        chk("directed_drained", 64'(exp_q.size()), 64'd0);

        // 100 back-to-back random transactions at full rate.
        n_xfer = 0;
        for (int i = 0; i < 100; i++) begin
            rnd();
            cyc(1'b1, ra[WA-1:0], rb[WB-1:0], rb[31], 1'b1);
        end
        chk("b2b_rate", 64'(n_xfer), 64'(100 - NSTG));
        idle(NSTG + 1);
        chk("b2b_count", 64'(n_xfer), 64'd100);
        chk("b2b_drained", 64'(exp_q.size()), 64'd0);

        // Stall with a full pipeline for 5 cycles while new input is offered.
        n_xfer = 0;
        for (int i = 0; i < NSTG; i++) begin
            rnd();
            cyc(1'b1, ra[WA-1:0], rb[WB-1:0], rb[31], 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            rnd();
            bus.in_valid = 1'b1; bus.a = ra[WA-1:0]; bus.b = rb[WB-1:0]; bus.b_sext = rb[31];
            bus.out_ready = 1'b0;
            #1;
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_sum_hold", 64'(bus.sum), 64'(exp_q[0]));
            cyc(1'b1, ra[WA-1:0], rb[WB-1:0], rb[31], 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            rnd();
            cyc(1'b1, ra[WA-1:0], rb[WB-1:0], rb[31], 1'b1);
        end
        idle(NSTG + 1);
        chk("stall_count", 64'(n_xfer), 64'(NSTG + 3));
        chk("stall_drained", 64'(exp_q.size()), 64'd0);

        // Random valid/ready mix.
        for (int i = 0; i < 300; i++) begin
            rnd();
            cyc(rb[30] | rb[29], ra[WA-1:0], rb[WB-1:0], rb[31], rb[28] | rb[27]);
        end
        idle(NSTG + 1);
        chk("mix_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            rnd();
            cyc(1'b1, ra[WA-1:0], rb[WB-1:0], rb[31], 1'b1);
        end
        rst_n = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_sum", 64'(bus.sum), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_ready", 64'(bus.in_ready), 64'd1);
        n_xfer = 0;
        for (int i = 0; i < NSTG + 2; i++) begin
            idle(1);
            chk("no_stale", 64'(bus.out_valid), 64'd0);
        end
        chk("no_stale_xfers", 64'(n_xfer), 64'd0);

`ifdef ADDER_XFER_CNT_EN
        chk("cnt_after_rst", 64'(xfer_cnt), 64'd0);
        for (int i = 0; i < 10; i++) begin
            rnd();
            cyc(1'b1, ra[WA-1:0], rb[WB-1:0], rb[31], 1'b1);
        end
        idle(NSTG + 1);
        chk("cnt_small", 64'(xfer_cnt), 64'(n_xfer));
        for (int i = 0; i < 70000; i++) begin
            rnd();
            cyc(1'b1, ra[WA-1:0], rb[WB-1:0], rb[31], 1'b1);
        end
        idle(NSTG + 1);
        chk("cnt_saturated", 64'(xfer_cnt), 64'hFFFF);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        chk("cnt_reset", 64'(xfer_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
